axi4l_read_master: RTL and testbench

AXI4-Lite read initiator that turns a simple valid/ready address-request stream into AR transactions and returns the R data, in order, on a valid/ready response stream. It sits between the occurrence-table lookup logic and the AXI4-Lite fabric or memory responder. It is read-only, so the write channels are tied off. It supports up to MAX_OUTSTANDING reads in flight and reserves response-buffer space before issuing each AR, so R is never back-pressured.

---
 rtl/axi4l_read_master.sv | 163 ++++++++++++++++
 tb/tb_axi4l_read_master.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4l_read_master.sv
// AXI4-Lite read initiator: accepts byte-offset read requests on a valid/ready
// stream, issues them as AR beats, and returns the R data in issue order on a
// valid/ready response stream. Request credits cover the AR register, the
// fabric and the response FIFO, so R is never back-pressured.
module axi4l_read_master #(
  parameter logic [39:0] BASE_ADDR       = 40'h00_0000_0000,
  parameter int          MAX_OUTSTANDING = 4,
  parameter int          DW              = 64
) (
  input  logic                                   clk,
  input  logic                                   rst,
  // request stream
  input  logic [39:0]                            req_addr,
  input  logic                                   req_valid,
  output logic                                   req_ready,
  // response stream
  output logic [DW-1:0]                          rsp_data,
  output logic                                   rsp_err,
  output logic                                   rsp_valid,
  input  logic                                   rsp_ready,
  // status
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   err_sticky,
  // AXI4-Lite write address channel (unused)
  output logic                                   awvalid,
  output logic [39:0]                            awaddr,
  output logic [2:0]                             awprot,
  input  logic                                   awready,
  // AXI4-Lite write data channel (unused)
  output logic                                   wvalid,
  output logic [DW-1:0]                          wdata,
  output logic [DW/8-1:0]                        wstrb,
  input  logic                                   wready,
  // AXI4-Lite write response channel (unused)
  input  logic                                   bvalid,
  input  logic [1:0]                             bresp,
  output logic                                   bready,
  // AXI4-Lite read address channel
  output logic                                   arvalid,
  output logic [39:0]                            araddr,
  output logic [2:0]                             arprot,
  input  logic                                   arready,
  // AXI4-Lite read data channel
  input  logic                                   rvalid,
  input  logic [DW-1:0]                          rdata,
  input  logic [1:0]                             rresp,
  output logic                                   rready
);

  localparam int              CW       = $clog2(MAX_OUTSTANDING + 1);
  localparam int              PW       = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0]   MAX_CNT  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0]   LAST_PTR = PW'(MAX_OUTSTANDING - 1);

  logic          req_fire;
  logic          ar_fire;
  logic          r_fire;
  logic          rsp_fire;

  logic [DW:0]   mem [MAX_OUTSTANDING];  // {err, data}
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_cnt;

  // Write-channel inputs are observed only to keep the port list complete.
  logic unused_write_rsp;
  assign unused_write_rsp = ^{awready, wready, bvalid, bresp};

  // Read-only master: write channels are permanently idle.
  assign awvalid = 1'b0;
  assign awaddr  = '0;
  assign awprot  = '0;
  assign wvalid  = 1'b0;
  assign wdata   = '0;
  assign wstrb   = '0;
  assign bready  = 1'b1;
  assign arprot  = 3'b000;

  // A credit is needed per request, and the AR register must be free or draining.
  assign req_ready = !rst && (outstanding < MAX_CNT) && (!arvalid || arready);
  assign rready    = !rst;

  assign req_fire  = req_valid & req_ready;
  assign ar_fire   = arvalid & arready;
  assign r_fire    = rvalid & rready;
  assign rsp_fire  = rsp_valid & rsp_ready;

  assign rsp_valid = (fifo_cnt != '0);
  assign rsp_err   = mem[rd_ptr][DW];
  assign rsp_data  = mem[rd_ptr][DW-1:0];

  // AR register: loads on request fire, holds until the fabric takes it.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge value of its inputs regardless of block ordering.
    if (rst) begin
      arvalid <= 1'b0;
      araddr  <= '0;
    end else if (req_fire) begin
      arvalid <= 1'b1;
      araddr  <= BASE_ADDR + req_addr;
    end else if (ar_fire) begin
      arvalid <= 1'b0;
    end
  end

  // Occupancy: requests held anywhere between acceptance and response pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else if (req_fire && !rsp_fire) begin
      outstanding <= outstanding + 1'b1;
    end else if (rsp_fire && !req_fire) begin
      outstanding <= outstanding - 1'b1;
    end
  end

  // Response FIFO: R beats pushed at the tail, head presented on rsp_*.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      // NOTE: the storage is reset because the head entry drives rsp_data and
      // rsp_err directly; it is only MAX_OUTSTANDING entries deep.
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (r_fire) begin
        mem[wr_ptr] <= {(rresp != 2'b00), rdata};
        wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (rsp_fire) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({r_fire, rsp_fire})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Sticky error flag: any non-OKAY read response since reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else if (r_fire && (rresp != 2'b00)) begin
      err_sticky <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  // The credit scheme reserves a FIFO slot before every AR, so a beat can never meet a full FIFO.
  always_ff @(posedge clk) begin
    if (!rst && r_fire) begin
      assert (fifo_cnt != MAX_CNT);
    end
  end
`endif

endmodule

// File: tb/tb_axi4l_read_master.sv
// Self-checking bench for axi4l_read_master: a behavioural AXI4-Lite read
// responder, a scoreboard of expected responses filled at request acceptance,
// and a monitor that pops and compares whenever a response is consumed.
module tb_axi4l_read_master;

  localparam logic [39:0] BASE = 40'h10_0000_0000;
  localparam int          MAXO = 4;
  localparam int          DW   = 64;
  localparam int          CW   = $clog2(MAXO + 1);

  logic            clk;
  logic            rst;
  logic [39:0]     req_addr;
  logic            req_valid;
  logic            req_ready;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [CW-1:0]   outstanding;
  logic            err_sticky;
  logic            awvalid;
  logic [39:0]     awaddr;
  logic [2:0]      awprot;
  logic            awready;
  logic            wvalid;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wready;
  logic            bvalid;
  logic [1:0]      bresp;
  logic            bready;
  logic            arvalid;
  logic [39:0]     araddr;
  logic [2:0]      arprot;
  logic            arready;
  logic            rvalid;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rready;

  axi4l_read_master #(
    .BASE_ADDR       (BASE),
    .MAX_OUTSTANDING (MAXO),
    .DW              (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_addr    (req_addr),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .outstanding (outstanding),
    .err_sticky  (err_sticky),
    .awvalid     (awvalid),
    .awaddr      (awaddr),
    .awprot      (awprot),
    .awready     (awready),
    .wvalid      (wvalid),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .wready      (wready),
    .bvalid      (bvalid),
    .bresp       (bresp),
    .bready      (bready),
    .arvalid     (arvalid),
    .araddr      (araddr),
    .arprot      (arprot),
    .arready     (arready),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .rresp       (rresp),
    .rready      (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct { logic [63:0] data; logic err; } exp_t;
  typedef struct { logic [39:0] addr; int due; } ar_t;

  exp_t        exp_q[$];
  ar_t         pend[$];
  exp_t        mon_e;

  // Responder / environment controls
  int          ar_mode;        // 0: always ready, 1: 50% random
  int          lat_mode;       // 0: 1 cycle, 1: geometric mean 10, 2: 20 cycles
  bit          rsp_rand;
  bit          force_data_en;
  logic [63:0] force_data;
  bit          r_fired;
  bit          stalled;
  logic [39:0] stall_addr;
  logic [39:0] last_araddr;
  int          ar_count;
  int          err_watch;
  int          rsp_seen_cyc;
  int          last_fire_cyc;

  // Memory contents and error map of the modelled responder.
  function automatic logic [63:0] data_of(input logic [39:0] a);
    return {a[23:0], a} ^ 64'h5A5A_C3C3_0F0F_9696;
  endfunction

  function automatic logic err_of(input logic [39:0] a);
    return a[15:12] == 4'hE;
  endfunction

  function automatic logic [1:0] resp_of(input logic [39:0] a);
    if (!err_of(a)) return 2'b00;
    return a[3] ? 2'b11 : 2'b10;
  endfunction

  function automatic logic [39:0] rand_addr();
    logic [39:0] a;
    a[39:32] = 8'($urandom);
    a[31:0]  = $urandom;
    a[2:0]   = 3'b000;
    return a;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: an accepted request returns the word at BASE+offset (mod 2^40).
  task automatic push_exp(input logic [39:0] ra);
    logic [39:0] a;
    exp_t        e;
    a      = BASE + ra;
    e.data = force_data_en ? force_data : data_of(a);
    e.err  = err_of(a);
    exp_q.push_back(e);
  endtask

  // Offer up to n requests within max_cyc cycles; returns how many were accepted.
  task automatic offer(input int n, input int max_cyc, input bit use_fixed,
                       input logic [39:0] fixed, output int fired);
    fired     = 0;
    req_addr  = use_fixed ? fixed : rand_addr();
    req_valid = 1'b1;
    for (int c = 0; c < max_cyc && fired < n; c++) begin
      bit took;
      @(negedge clk);
      took = req_ready;
      if (took) begin
        push_exp(req_addr);
        fired++;
        last_fire_cyc = cyc;
      end
      @(posedge clk);
      #1;
      if (took) req_addr = use_fixed ? fixed : rand_addr();
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    bit done;
    done = 1'b0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      @(negedge clk);
      done = (outstanding == '0) && !rsp_valid && (exp_q.size() == 0);
    end
    check(name, 64'(done), 64'd1);
    @(posedge clk);
    #1;
  endtask

  // Responder drive side: arready pattern and in-order R beats once due.
  always @(posedge clk) begin
    #1;
    case (ar_mode)
      0:       arready = 1'b1;
      1:       arready = 1'($urandom_range(0, 1));
      default: arready = 1'b0;
    endcase
    if (rsp_rand) rsp_ready = ($urandom_range(0, 3) != 0);
    if (!rvalid || r_fired || pend.size() == 0) begin
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        rvalid = 1'b1;
        rdata  = force_data_en ? force_data : data_of(pend[0].addr);
        rresp  = resp_of(pend[0].addr);
      end else begin
        rvalid = 1'b0;
        rdata  = '0;
        rresp  = 2'b00;
      end
    end
    r_fired = 1'b0;
  end

  // Responder sample side: AR capture, AR stability, R consumption, err_sticky timing.
  always @(negedge clk) begin
    int lat;
    if (rst) begin
      pend.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("ar_hold_valid", 64'(arvalid), 64'd1);
        check("ar_hold_addr", 64'(araddr), 64'(stall_addr));
      end
      stalled    = arvalid && !arready;
      stall_addr = araddr;
      if (arvalid && arready) begin
        case (lat_mode)
          0: lat = 1;
          1: begin
            lat = 1;
            while ($urandom_range(0, 9) != 0) lat++;
          end
          default: lat = 20;
        endcase
        pend.push_back('{addr: araddr, due: cyc + lat});
        last_araddr = araddr;
        ar_count++;
      end
      if (rvalid && rready) begin
        if (rresp != 2'b00) err_watch = cyc;
        void'(pend.pop_front());
        r_fired = 1'b1;
      end
      if (err_watch >= 0 && cyc == err_watch + 1) check("err_sticky_set", 64'(err_sticky), 64'd1);
    end
  end

  // Scoreboard monitor: every consumed response must match the oldest expectation.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (rsp_valid && rsp_seen_cyc < 0) rsp_seen_cyc = cyc;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_data", rsp_data, mon_e.data);
          check("rsp_err", 64'(rsp_err), 64'(mon_e.err));
        end
      end
    end
  end

  // Occupancy must equal the number of accepted, not yet consumed requests.
  always @(posedge clk) begin
    #2;
    if (!rst) check("outstanding", 64'(outstanding), 64'(exp_q.size()));
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fired;
    int ar_base;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    ar_mode = 0; lat_mode = 0; rsp_rand = 1'b0; force_data_en = 1'b0; force_data = '0;
    r_fired = 1'b0; stalled = 1'b0; stall_addr = '0; last_araddr = '0;
    ar_count = 0; err_watch = -1; rsp_seen_cyc = -1; last_fire_cyc = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rready", 64'(rready), 64'd0);
    check("rst_arvalid", 64'(arvalid), 64'd0);
    check("rst_araddr", 64'(araddr), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", rsp_data, 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_outstanding", 64'(outstanding), 64'd0);
    check("rst_err_sticky", 64'(err_sticky), 64'd0);
    check("tie_awvalid", 64'(awvalid), 64'd0);
    check("tie_wvalid", 64'(wvalid), 64'd0);
    check("tie_bready", 64'(bready), 64'd1);
    check("tie_arprot", 64'(arprot), 64'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Single read with minimum latency
    force_data    = 64'h0123_4567_89AB_CDEF;
    force_data_en = 1'b1;
    rsp_ready     = 1'b1;
    rsp_seen_cyc  = -1;
    offer(1, 20, 1'b1, 40'h40, fired);
    check("single_fired", 64'(fired), 64'd1);
    wait_idle("single_idle", 100);
    check("single_araddr", 64'(last_araddr), 64'h10_0000_0040);
    check("single_latency", 64'(rsp_seen_cyc - last_fire_cyc), 64'd3);
    force_data_en = 1'b0;

    // Error on the middle of three reads
    check("err_sticky_pre", 64'(err_sticky), 64'd0);
    offer(1, 20, 1'b1, 40'h100, fired);
    offer(1, 20, 1'b1, 40'hE000, fired);
    offer(1, 20, 1'b1, 40'h200, fired);
    wait_idle("err_idle", 100);
    check("err_sticky_post", 64'(err_sticky), 64'd1);

    // Full boundary with rsp_ready held low
    rsp_ready = 1'b0;
    ar_base   = ar_count;
    offer(6, 40, 1'b0, '0, fired);
    check("bp_fired", 64'(fired), 64'd4);
    check("bp_ar_count", 64'(ar_count - ar_base), 64'd4);
    @(negedge clk);
    check("bp_outstanding", 64'(outstanding), 64'd4);
    check("bp_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = rand_addr(); rsp_ready = 1'b1;
    @(negedge clk);
    check("pop_cycle_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("reopen_req_ready", 64'(req_ready), 64'd1);
    if (req_ready) push_exp(req_addr);
    @(posedge clk); #1;
    req_valid = 1'b0;
    offer(1, 10, 1'b0, '0, fired);
    check("bp_no_more", 64'(fired), 64'd0);
    check("bp_ar_count2", 64'(ar_count - ar_base), 64'd5);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_idle("bp_idle", 100);

    // Randomised traffic: 50% arready, geometric R latency, random rsp_ready
    ar_mode = 1; lat_mode = 1; rsp_rand = 1'b1;
    offer(1000, 30000, 1'b0, '0, fired);
    check("rand_fired", 64'(fired), 64'd1000);
    wait_idle("rand_idle", 3000);
    rsp_rand = 1'b0; rsp_ready = 1'b1; ar_mode = 0;

    // Reset with three reads in flight
    lat_mode = 2;
    @(posedge clk); #1;
    offer(3, 20, 1'b0, '0, fired);
    check("rst_mid_fired", 64'(fired), 64'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_arvalid", 64'(arvalid), 64'd0);
    check("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_mid_outstanding", 64'(outstanding), 64'd0);
    check("rst_mid_err_sticky", 64'(err_sticky), 64'd0);
    @(posedge clk); #1;
    lat_mode = 0;
    offer(1, 20, 1'b0, '0, fired);
    check("post_rst_fired", 64'(fired), 64'd1);
    wait_idle("post_rst_idle", 100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
